// File: rtl/qddc_pkg.sv
// qddc_pkg
// Shared definitions for the quadrature DDC control slice: sequencer states,
// register addresses and the bit positions inside the flag and control words.
package qddc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    SETTLE   = 3'd2,
    RUN      = 3'd3,
    WAIT_BND = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_FREQ  = 2'd0;
  localparam logic [1:0] ADDR_FLAGS = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;

  // Bit positions in the flags word (address 1)
  localparam int FLAG_DIR     = 0;
  localparam int FLAG_NS_EN   = 1;
  localparam int FLAG_IQ_SWAP = 2;

  // Bit positions in the control word (address 2)
  localparam int CTRL_COMMIT   = 0;
  localparam int CTRL_NO_FLUSH = 1;

endpackage

// File: rtl/qddc_cfg_regs.sv
// qddc_cfg_regs
// Shadow (staged) register file for the DDC tuning settings. Decodes the
// write-only register bus and turns control writes into single-cycle commit
// and no_flush pulses for the sequencer.
//
// Ports:
//   i_clk, i_reset    clock, asynchronous active-high reset
//   i_cfg_wr          single-cycle write strobe
//   i_cfg_addr        register address
//   i_cfg_data        write data
//   o_freq            staged NCO tuning word
//   o_dir             staged NCO direction
//   o_ns_en           staged noise-shaping enable
//   o_iq_swap         staged IQ swap
//   o_commit          commit pulse (combinational, same cycle as the write)
//   o_no_flush        no_flush qualifier, valid only with o_commit
module qddc_cfg_regs
  import qddc_pkg::*;
#(
  parameter int FSZ = 31
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_cfg_wr,
  input  logic [1:0]     i_cfg_addr,
  input  logic [31:0]    i_cfg_data,
  output logic [FSZ-1:0] o_freq,
  output logic           o_dir,
  output logic           o_ns_en,
  output logic           o_iq_swap,
  output logic           o_commit,
  output logic           o_no_flush
);

  logic [FSZ-1:0] r_freq;
  logic           r_dir;
  logic           r_ns_en;
  logic           r_iq_swap;
  logic           w_ctrl_wr;
  logic           w_unused;

  // Upper data bits are don't-care for every register
  assign w_unused = &{1'b0, i_cfg_data};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_freq    <= '0;
      r_dir     <= 1'b0;
      r_ns_en   <= 1'b0;
      r_iq_swap <= 1'b0;
    end else if (i_cfg_wr) begin
      if (i_cfg_addr == ADDR_FREQ) begin
        r_freq <= i_cfg_data[FSZ-1:0];
      end
      if (i_cfg_addr == ADDR_FLAGS) begin
        r_dir     <= i_cfg_data[FLAG_DIR];
        r_ns_en   <= i_cfg_data[FLAG_NS_EN];
        r_iq_swap <= i_cfg_data[FLAG_IQ_SWAP];
      end
    end
  end

  // Commit is left combinational so the active copy happens on the very
  // edge that samples the control write.
  assign w_ctrl_wr  = i_cfg_wr && (i_cfg_addr == ADDR_CTRL);
  assign o_commit   = w_ctrl_wr && i_cfg_data[CTRL_COMMIT];
  assign o_no_flush = w_ctrl_wr && i_cfg_data[CTRL_COMMIT] && i_cfg_data[CTRL_NO_FLUSH];

  assign o_freq    = r_freq;
  assign o_dir     = r_dir;
  assign o_ns_en   = r_ns_en;
  assign o_iq_swap = r_iq_swap;

endmodule

// File: rtl/qddc_ctrl.sv
// qddc_ctrl
// Run-time configuration and retune sequencer for the quadrature DDC.
// Staged settings are applied atomically on a commit, optionally flushing the
// DDC through its reset and discarding CIC transient samples before the
// output stream is re-opened.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   cfg_wr/addr/data     register write bus
//   ddc_valid/i/q        DDC output stream
//   ddc_reset            reset driven into the DDC
//   lo_freq/lo_dir/lo_ns_en/iq_swap   active tuning settings
//   out_valid/i/q        gated stream toward the consumer (1-cycle latency)
//   busy                 high whenever the sequencer is not in RUN
//   commit_cnt           completed commits, wraps 255 -> 0
module qddc_ctrl
  import qddc_pkg::*;
#(
  parameter int FSZ            = 31,
  parameter int OSZ            = 16,
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_SAMPLES = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_wr,
  input  logic [1:0]     cfg_addr,
  input  logic [31:0]    cfg_data,
  input  logic           ddc_valid,
  input  logic [OSZ-1:0] ddc_i,
  input  logic [OSZ-1:0] ddc_q,
  output logic           ddc_reset,
  output logic [FSZ-1:0] lo_freq,
  output logic           lo_dir,
  output logic           lo_ns_en,
  output logic           iq_swap,
  output logic           out_valid,
  output logic [OSZ-1:0] out_i,
  output logic [OSZ-1:0] out_q,
  output logic           busy,
  output logic [7:0]     commit_cnt
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int SCW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;

  state_t         r_state;
  state_t         w_state_next;
  logic [FCW-1:0] r_flush_cnt;
  logic [SCW-1:0] r_settle_cnt;
  logic           r_pend;
  logic           r_pend_nf;
  logic [FSZ-1:0] r_freq;
  logic           r_dir;
  logic           r_ns_en;
  logic           r_iq_swap;
  logic           r_out_valid;
  logic [OSZ-1:0] r_out_i;
  logic [OSZ-1:0] r_out_q;
  logic [7:0]     r_commit_cnt;

  logic [FSZ-1:0] w_sh_freq;
  logic           w_sh_dir;
  logic           w_sh_ns_en;
  logic           w_sh_iq_swap;
  logic           w_commit;
  logic           w_no_flush;
  logic           w_go;
  logic           w_go_nf;
  logic           w_load_active;
  logic           w_enter_run;
  logic           w_stream_open;
  logic           w_in_seq;

  qddc_cfg_regs #(
    .FSZ(FSZ)
  ) u_cfg_regs (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_cfg_wr   (cfg_wr),
    .i_cfg_addr (cfg_addr),
    .i_cfg_data (cfg_data),
    .o_freq     (w_sh_freq),
    .o_dir      (w_sh_dir),
    .o_ns_en    (w_sh_ns_en),
    .o_iq_swap  (w_sh_iq_swap),
    .o_commit   (w_commit),
    .o_no_flush (w_no_flush)
  );

  // A sequence always lands in RUN for one cycle (so it is counted); a
  // pending commit is then consumed there exactly like a fresh one, merged
  // with any commit arriving on that same cycle.
  assign w_go    = w_commit || r_pend;
  assign w_go_nf = r_pend ? (r_pend_nf || w_no_flush) : w_no_flush;

  always_comb begin
    w_state_next  = r_state;
    w_load_active = 1'b0;
    case (r_state)
      IDLE: begin
        // no_flush is meaningless before the DDC has ever run
        if (w_commit) begin
          w_state_next  = FLUSH;
          w_load_active = 1'b1;
        end
      end
      FLUSH: begin
        if (r_flush_cnt == FCW'(FLUSH_CYCLES - 1)) begin
          w_state_next = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
        end
      end
      SETTLE: begin
        if (ddc_valid && (r_settle_cnt == SCW'(SETTLE_SAMPLES - 1))) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_go) begin
          if (w_go_nf) begin
            w_state_next = WAIT_BND;
          end else begin
            w_state_next  = FLUSH;
            w_load_active = 1'b1;
          end
        end
      end
      WAIT_BND: begin
        // The boundary sample still carries the old settings downstream
        if (ddc_valid) begin
          w_state_next  = RUN;
          w_load_active = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_enter_run   = (w_state_next == RUN) && (r_state != RUN);
  assign w_stream_open = (r_state == RUN) || (r_state == WAIT_BND);
  assign w_in_seq      = (r_state == FLUSH) || (r_state == SETTLE) || (r_state == WAIT_BND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counters restart whenever their state is not active, so each entry
  // begins from zero without an explicit load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_cnt  <= '0;
      r_settle_cnt <= '0;
    end else begin
      if (r_state == FLUSH) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end else begin
        r_flush_cnt <= '0;
      end
      if (r_state != SETTLE) begin
        r_settle_cnt <= '0;
      end else if (ddc_valid) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_pend_nf <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_go) begin
        r_pend    <= 1'b0;
        r_pend_nf <= 1'b0;
      end
    end else if (w_in_seq && w_commit) begin
      r_pend    <= 1'b1;
      r_pend_nf <= r_pend_nf || w_no_flush;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_freq       <= '0;
      r_dir        <= 1'b0;
      r_ns_en      <= 1'b0;
      r_iq_swap    <= 1'b0;
      r_commit_cnt <= '0;
    end else begin
      if (w_load_active) begin
        r_freq    <= w_sh_freq;
        r_dir     <= w_sh_dir;
        r_ns_en   <= w_sh_ns_en;
        r_iq_swap <= w_sh_iq_swap;
      end
      if (w_enter_run) begin
        r_commit_cnt <= r_commit_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_i     <= '0;
      r_out_q     <= '0;
    end else begin
      r_out_valid <= ddc_valid && w_stream_open;
      if (ddc_valid) begin
        r_out_i <= ddc_i;
        r_out_q <= ddc_q;
      end
    end
  end

  assign ddc_reset  = (r_state == IDLE) || (r_state == FLUSH);
  assign busy       = (r_state != RUN);
  assign lo_freq    = r_freq;
  assign lo_dir     = r_dir;
  assign lo_ns_en   = r_ns_en;
  assign iq_swap    = r_iq_swap;
  assign out_valid  = r_out_valid;
  assign out_i      = r_out_i;
  assign out_q      = r_out_q;
  assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_qddc_ctrl.sv
// tb_qddc_ctrl
// Self-checking bench for qddc_ctrl. Samples expected to reach the consumer
// are queued when driven and popped by a monitor whenever out_valid appears.
module tb_qddc_ctrl;

  localparam int FSZ = 31;
  localparam int OSZ = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cfg_wr = 1'b0;
  logic [1:0]     cfg_addr = '0;
  logic [31:0]    cfg_data = '0;
  logic           ddc_valid = 1'b0;
  logic [OSZ-1:0] ddc_i = '0;
  logic [OSZ-1:0] ddc_q = '0;
  logic           ddc_reset;
  logic [FSZ-1:0] lo_freq;
  logic           lo_dir;
  logic           lo_ns_en;
  logic           iq_swap;
  logic           out_valid;
  logic [OSZ-1:0] out_i;
  logic [OSZ-1:0] out_q;
  logic           busy;
  logic [7:0]     commit_cnt;

  int nChecks = 0;
  int nFails  = 0;
  logic [2*OSZ-1:0] expQ[$];

  qddc_ctrl #(
    .FSZ(FSZ), .OSZ(OSZ), .FLUSH_CYCLES(4), .SETTLE_SAMPLES(3)
  ) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ddc_valid(ddc_valid), .ddc_i(ddc_i), .ddc_q(ddc_q),
    .ddc_reset(ddc_reset), .lo_freq(lo_freq), .lo_dir(lo_dir),
    .lo_ns_en(lo_ns_en), .iq_swap(iq_swap), .out_valid(out_valid),
    .out_i(out_i), .out_q(out_q), .busy(busy), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every out_valid must match the oldest queued sample
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out", {out_i, out_q}, 64'hDEAD);
      end else begin
        checkOutput("stream_data", {out_i, out_q}, expQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input logic [1:0] addr, input logic [31:0] data);
    cfg_wr   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_wr   = 1'b0;
  endtask

  // One ddc_valid pulse with random data; fwd says whether it must reach out_*
  task automatic applyStimulus(input logic fwd, input logic gap);
    ddc_valid = 1'b1;
    ddc_i = OSZ'($urandom);
    ddc_q = OSZ'($urandom);
    if (fwd) expQ.push_back({ddc_i, ddc_q});
    tick();
    ddc_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic waitFlushDone();
    int n = 0;
    while (ddc_reset && n < 20) begin
      n++;
      tick();
    end
    if (ddc_reset) checkOutput("flush_timeout", 1, 0);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 20) begin
      n++;
      tick();
    end
    checkOutput("drain", expQ.size(), 0);
  endtask

  task automatic dropSettle();
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1);
  endtask

  initial begin
    int rcnt;
    repeat (2) tick();
    checkOutput("rst_ddc_reset", ddc_reset, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_commit_cnt", commit_cnt, 0);
    checkOutput("rst_lo_freq", lo_freq, 0);
    reset = 1'b0;
    tick();

    // Flush commit from IDLE
    cfgWrite(2'd0, 32'h1234_5678);
    cfgWrite(2'd1, 32'h5);
    cfgWrite(2'd2, 32'h1);
    checkOutput("t1_lo_freq", lo_freq, 64'h1234_5678);
    checkOutput("t1_lo_dir", lo_dir, 1);
    checkOutput("t1_lo_ns_en", lo_ns_en, 0);
    checkOutput("t1_iq_swap", iq_swap, 1);
    rcnt = 0;
    while (ddc_reset && rcnt < 20) begin
      rcnt++;
      tick();
    end
    checkOutput("t1_flush_len", rcnt, 4);
    checkOutput("t1_busy_settle", busy, 1);
    dropSettle();
    checkOutput("t1_busy_run", busy, 0);
    applyStimulus(1'b1, 1'b1);
    waitDrain();
    checkOutput("t1_commit_cnt", commit_cnt, 1);

    // no_flush retune at a sample boundary
    cfgWrite(2'd0, 32'h100);
    checkOutput("t2_shadow_iso", lo_freq, 64'h1234_5678);
    cfgWrite(2'd2, 32'h3);
    checkOutput("t2_busy_wait", busy, 1);
    checkOutput("t2_lo_freq_old", lo_freq, 64'h1234_5678);
    tick();
    tick();
    checkOutput("t2_ddc_reset", ddc_reset, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_lo_freq_new", lo_freq, 64'h100);
    checkOutput("t2_busy_run", busy, 0);
    applyStimulus(1'b1, 1'b1);
    waitDrain();
    checkOutput("t2_commit_cnt", commit_cnt, 2);

    // Commit during SETTLE collapses into a second flush with newest shadow
    cfgWrite(2'd2, 32'h1);
    checkOutput("t3_lo_freq_a", lo_freq, 64'h100);
    waitFlushDone();
    cfgWrite(2'd2, 32'h1);
    cfgWrite(2'd0, 32'h200);
    checkOutput("t3_lo_freq_hold", lo_freq, 64'h100);
    dropSettle();
    checkOutput("t3_reflush", ddc_reset, 1);
    checkOutput("t3_lo_freq_b", lo_freq, 64'h200);
    checkOutput("t3_commit_mid", commit_cnt, 3);
    waitFlushDone();
    dropSettle();
    applyStimulus(1'b1, 1'b1);
    waitDrain();
    checkOutput("t3_commit_cnt", commit_cnt, 4);

    // Shadow write without commit; back-to-back samples all forwarded
    cfgWrite(2'd0, 32'hABC);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0);
    waitDrain();
    checkOutput("t5_lo_freq", lo_freq, 64'h200);
    checkOutput("t5_commit_cnt", commit_cnt, 4);

    // Async reset in the middle of a flush
    cfgWrite(2'd2, 32'h1);
    checkOutput("t4_lo_freq_pre", lo_freq, 64'hABC);
    tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("t4_ddc_reset", ddc_reset, 1);
    checkOutput("t4_out_valid", out_valid, 0);
    checkOutput("t4_lo_freq", lo_freq, 0);
    checkOutput("t4_commit_cnt", commit_cnt, 0);
    checkOutput("t4_out_i", out_i, 0);
    checkOutput("t4_busy", busy, 1);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("t4_idle_ddc_reset", ddc_reset, 1);

    // Address 3 is ignored; 256 flush commits wrap the counter
    cfgWrite(2'd3, 32'hFFFF_FFFF);
    checkOutput("t6_addr3_freq", lo_freq, 0);
    checkOutput("t6_addr3_busy", busy, 1);
    for (int k = 0; k < 256; k++) begin
      cfgWrite(2'd2, 32'h1);
      waitFlushDone();
      dropSettle();
      if (k == 254) checkOutput("t6_cnt_255", commit_cnt, 255);
    end
    checkOutput("t6_commit_wrap", commit_cnt, 0);
    checkOutput("t6_lo_freq", lo_freq, 0);
    checkOutput("t6_flags", {lo_dir, lo_ns_en, iq_swap}, 0);
    checkOutput("t6_busy", busy, 0);
    applyStimulus(1'b1, 1'b1);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
